// File: rtl/pe_dot_accum_ctrl_pkg.sv
// Shared types, default sizes and the saturating-add helper for the dot-product accumulator controller.
package pe_dot_accum_ctrl_pkg;

  localparam int DEF_DOT_LATENCY = 4;
  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_DOT_WIDTH   = 24;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH  = 8;

  // Operand width of sat_add; callers sign-extend into it and keep the low bits.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pe_dot_ctrl_state_t;

  // Returns {saturated, value}; value is clamped to the signed range of 'width' bits.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int width);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    for (int i = 0; i <= SAT_W; i++) hi[i] = (i < width - 1);
    lo = ~hi;
    if (s > hi) return {1'b1, hi[SAT_W-1:0]};
    if (s < lo) return {1'b1, lo[SAT_W-1:0]};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/pe_dot_accum_ctrl_if.sv
// Block feeder, dot array and writeback signals of the dot-product accumulator controller.
interface pe_dot_accum_ctrl_if import pe_dot_accum_ctrl_pkg::*; #(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DOT_WIDTH = DEF_DOT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
  logic                           i_valid;
  logic                           o_ready;
  logic                           i_last;
  logic                           i_flush;
  logic                           o_dot_issue;
  logic [NUM_LANES*DOT_WIDTH-1:0] i_dot_result;
  logic [NUM_LANES*ACC_WIDTH-1:0] o_result;
  logic                           o_valid;
  logic                           i_ready;
  logic                           o_busy;
  logic                           o_overflow;

  modport master (
    output i_valid, i_last, i_flush, i_dot_result, i_ready,
    input  o_ready, o_dot_issue, o_result, o_valid, o_busy, o_overflow
  );

  modport slave (
    input  i_valid, i_last, i_flush, i_dot_result, i_ready,
    output o_ready, o_dot_issue, o_result, o_valid, o_busy, o_overflow
  );
endinterface

// File: rtl/pe_dot_accum_ctrl_fifo.sv
// Synchronous show-ahead result FIFO; head is valid whenever count is non-zero.
module pe_result_fifo import pe_dot_accum_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_ACC_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The controller's credit scheme reserves a slot for every in-flight final block.
  assert property (@(posedge clock) disable iff (!resetn) !(push && full));

endmodule

// File: rtl/pe_dot_accum_ctrl.sv
// Issues blocks to the non-stallable dot array, accumulates per-lane results over multi-block
// dot products and buffers finished sums in a FIFO, admitting input only while FIFO credit remains.
module pe_dot_accum_ctrl import pe_dot_accum_ctrl_pkg::*; #(
  parameter int DOT_LATENCY = DEF_DOT_LATENCY,
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int DOT_WIDTH   = DEF_DOT_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic               clock,
  input logic               resetn,
  pe_dot_accum_ctrl_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int RW = NUM_LANES*ACC_WIDTH;

  pe_dot_ctrl_state_t   state;
  logic [DOT_LATENCY-1:0] sr_v;
  logic [DOT_LATENCY-1:0] sr_last;
  logic [CW-1:0]        pend;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [RW-1:0]        acc;
  logic [RW-1:0]        sum;
  logic [NUM_LANES-1:0] lane_sat;
  logic                 acc_empty;
  logic                 overflow;
  logic                 credit_ok;
  logic                 accept;
  logic                 ret_v;
  logic                 ret_last;
  logic                 push;
  logic                 sr_drained;
  logic                 acc_empty_next;

  assign credit_ok   = ({1'b0, pend} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign bus.o_ready = resetn & (state != DRAIN) & credit_ok;
  assign accept      = bus.i_valid & bus.o_ready;
  assign bus.o_dot_issue = accept;

  assign ret_v    = sr_v[DOT_LATENCY-1];
  assign ret_last = sr_last[DOT_LATENCY-1];
  assign push     = ret_v & ret_last;

  // True when no tracked beat remains after this cycle's shift; the tail is retiring now.
  assign sr_drained     = ((sr_v << 1) == '0);
  assign acc_empty_next = ret_v ? ret_last : acc_empty;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] acc_l;
    logic signed [DOT_WIDTH-1:0] dot_l;
    logic [SAT_W:0]              res;
    assign acc_l = acc_empty ? '0 : acc[l*ACC_WIDTH +: ACC_WIDTH];
    assign dot_l = bus.i_dot_result[l*DOT_WIDTH +: DOT_WIDTH];
    assign res   = sat_add(SAT_W'(acc_l), SAT_W'(dot_l), ACC_WIDTH);
    assign sum[l*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(res[SAT_W-1:0]);
    assign lane_sat[l] = res[SAT_W];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      sr_v      <= '0;
      sr_last   <= '0;
      pend      <= '0;
      acc       <= '0;
      acc_empty <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      sr_v    <= (sr_v << 1) | DOT_LATENCY'(accept);
      sr_last <= (sr_last << 1) | DOT_LATENCY'(accept & bus.i_last);

      if (ret_v) begin
        if (|lane_sat) overflow <= 1'b1;
        if (ret_last) begin
          acc_empty <= 1'b1;
        end else begin
          acc       <= sum;
          acc_empty <= 1'b0;
        end
      end

      case ({accept & bus.i_last, push})
        2'b10:   pend <= pend + 1'b1;
        2'b01:   pend <= pend - 1'b1;
        default: pend <= pend;
      endcase

      // Leaving DRAIN drops any partial sum; this overrides an accumulate in the same cycle.
      case (state)
        IDLE:    if (accept) state <= RUN;
        RUN: begin
          if (bus.i_flush) state <= DRAIN;
          else if (!accept && sr_drained && acc_empty_next) state <= IDLE;
        end
        DRAIN: begin
          if (sr_drained) begin
            state     <= IDLE;
            acc_empty <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pe_result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (sum),
    .pop       (bus.o_valid & bus.i_ready),
    .head      (bus.o_result),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.o_valid    = resetn & ~fifo_empty;
  assign bus.o_busy     = resetn & ((state != IDLE) | ~fifo_empty);
  assign bus.o_overflow = overflow;

endmodule
